// File: rtl/i2c_byte_fifo.sv
// Byte FIFO between the AXI register block and the I2C controller, with optional edge-detected push/pop.
// Latency: a pushed byte is visible on pop_data one cycle later; a pop advances the head one cycle later.
// Backpressure: none; a push into a full FIFO is dropped (sticky overflow), a pop from empty sets sticky underflow.
module i2c_byte_fifo #(
   parameter int DEPTH     = 16,
   parameter int AW        = $clog2(DEPTH),
   parameter bit PUSH_EDGE = 1'b0,
   parameter bit POP_EDGE  = 1'b1
) (
   input  logic          axi_clk,
   input  logic          axi_resetn,
   input  logic          clear,
   input  logic          push,
   input  logic [31:0]   push_data,
   input  logic          pop,
   output logic [31:0]   pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          underflow
);

   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          push_q, pop_q;
   logic          push_ev, pop_ev;
   logic          wr_en;
   logic          unused_hi;

   // Only the low byte is stored; the upper bits of the AXI word are don't-care.
   assign unused_hi = ^push_data[31:8];

   // A request held high across many cycles counts once in edge mode.
   assign push_ev = push & (PUSH_EDGE ? ~push_q : 1'b1);
   assign pop_ev  = pop  & (POP_EDGE  ? ~pop_q  : 1'b1);

   assign full      = (count_q == CNT_FULL);
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign pop_data  = empty ? 32'h0 : {24'h0, mem_q[rd_ptr_q]};

   // Next-state: clear wins, then the push/pop combinations.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      wr_en    = 1'b0;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else if (push_ev && pop_ev) begin
         wr_en    = 1'b1;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (empty) begin
            // The pop finds nothing; the new entry stays for a later pop.
            count_d = CNT_ONE;
            unf_d   = 1'b1;
         end else begin
            // When full the pop frees the head slot that wr_ptr aliases.
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
      end else if (push_ev) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
         end
      end else if (pop_ev) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
         end
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Delayed request copies for edge detection; these ignore clear.
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         push_q <= 1'b0;
         pop_q  <= 1'b0;
      end else begin
         push_q <= push;
         pop_q  <= pop;
      end
   end

   // Storage array; contents are not reset.
   always_ff @(posedge axi_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_data[7:0];
      end
   end

endmodule

// File: tb/tb_i2c_byte_fifo.sv
// Directed bench for i2c_byte_fifo in TX (level push / edge pop) and RX (edge push / level pop) configurations.
// Inputs change 1 time unit after a rising edge and outputs are sampled at that same point.
// Each comparison is an immediate assertion; failures are counted and summarised at the end.
module tb_i2c_byte_fifo;

   logic        axi_clk = 1'b0;
   logic        axi_resetn = 1'b0;
   logic        clear = 1'b0;

   logic        tx_push = 1'b0, tx_pop = 1'b0;
   logic [31:0] tx_data = 32'h0;
   logic [31:0] tx_pop_data;
   logic        tx_full, tx_empty, tx_ovf, tx_unf;
   logic [4:0]  tx_count;

   logic        rx_push = 1'b0, rx_pop = 1'b0;
   logic [31:0] rx_data = 32'h0;
   logic [31:0] rx_pop_data;
   logic        rx_full, rx_empty, rx_ovf, rx_unf;
   logic [4:0]  rx_count;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 axi_clk = ~axi_clk;

   i2c_byte_fifo #(.DEPTH(16), .PUSH_EDGE(1'b0), .POP_EDGE(1'b1)) u_tx (
      .axi_clk    (axi_clk),
      .axi_resetn (axi_resetn),
      .clear      (clear),
      .push       (tx_push),
      .push_data  (tx_data),
      .pop        (tx_pop),
      .pop_data   (tx_pop_data),
      .full       (tx_full),
      .empty      (tx_empty),
      .count      (tx_count),
      .overflow   (tx_ovf),
      .underflow  (tx_unf)
   );

   i2c_byte_fifo #(.DEPTH(16), .PUSH_EDGE(1'b1), .POP_EDGE(1'b0)) u_rx (
      .axi_clk    (axi_clk),
      .axi_resetn (axi_resetn),
      .clear      (clear),
      .push       (rx_push),
      .push_data  (rx_data),
      .pop        (rx_pop),
      .pop_data   (rx_pop_data),
      .full       (rx_full),
      .empty      (rx_empty),
      .count      (rx_count),
      .overflow   (rx_ovf),
      .underflow  (rx_unf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge axi_clk);
      #1;
   endtask

   task automatic tx_push_byte(input logic [7:0] b);
      tx_push = 1'b1;
      tx_data = {24'hABCDEF, b};
      tick();
      tx_push = 1'b0;
   endtask

   task automatic tx_pop_once();
      tx_pop = 1'b1;
      tick();
      tx_pop = 1'b0;
      tick();
   endtask

   task automatic rx_push_once(input logic [31:0] d);
      rx_push = 1'b1;
      rx_data = d;
      tick();
      rx_push = 1'b0;
      tick();
   endtask

   initial begin
      // Reset defaults
      repeat (2) @(posedge axi_clk);
      #1 axi_resetn = 1'b1;
      tick();
      chk("rst_count", 32'(tx_count), 32'd0);
      chk("rst_empty", 32'(tx_empty), 32'd1);
      chk("rst_full",  32'(tx_full),  32'd0);
      chk("rst_data",  tx_pop_data,   32'h0);
      chk("rst_ovf",   32'(tx_ovf),   32'd0);
      chk("rst_unf",   32'(tx_unf),   32'd0);
      chk("rst_rx_empty", 32'(rx_empty), 32'd1);

      // Basic order: level push on consecutive cycles
      tx_push = 1'b1;
      tx_data = 32'h11; tick();
      tx_data = 32'h22; tick();
      tx_data = 32'h33; tick();
      tx_push = 1'b0;
      chk("push3_count", 32'(tx_count), 32'd3);
      chk("push3_head",  tx_pop_data,   32'h11);

      // Edge pop held for 500 cycles pops exactly once
      tx_pop = 1'b1;
      repeat (500) tick();
      tx_pop = 1'b0;
      tick();
      chk("hold_pop_head",  tx_pop_data,   32'h22);
      chk("hold_pop_count", 32'(tx_count), 32'd2);
      chk("hold_pop_unf",   32'(tx_unf),   32'd0);
      tx_pop_once();
      tx_pop_once();
      chk("drain_empty", 32'(tx_empty), 32'd1);
      chk("drain_data",  tx_pop_data,   32'h0);

      // Fill (pointers start at 3, so the write pointer wraps), overflow, drain
      for (int i = 0; i < 16; i++) tx_push_byte(8'(i));
      chk("fill_full",  32'(tx_full),  32'd1);
      chk("fill_count", 32'(tx_count), 32'd16);
      tx_push_byte(8'hAA);
      chk("ovf_flag",  32'(tx_ovf),   32'd1);
      chk("ovf_count", 32'(tx_count), 32'd16);
      for (int i = 0; i < 16; i++) begin
         chk("drain_order", tx_pop_data, 32'(i));
         tx_pop_once();
      end
      chk("drain16_empty", 32'(tx_empty), 32'd1);
      chk("ovf_sticky",    32'(tx_ovf),   32'd1);
      tx_push_byte(8'h55);
      chk("wrap_data", tx_pop_data, 32'h55);
      tx_pop_once();

      // Clear, then refill and push+pop together while full
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clear_ovf", 32'(tx_ovf), 32'd0);
      for (int i = 0; i < 16; i++) tx_push_byte(8'(8'h20 + i));
      tx_push = 1'b1; tx_pop = 1'b1; tx_data = 32'h77;
      tick();
      tx_push = 1'b0; tx_pop = 1'b0;
      tick();
      chk("fullpp_count", 32'(tx_count), 32'd16);
      chk("fullpp_ovf",   32'(tx_ovf),   32'd0);
      chk("fullpp_head",  tx_pop_data,   32'h21);
      for (int i = 1; i < 16; i++) begin
         chk("fullpp_order", tx_pop_data, 32'(8'h20 + i));
         tx_pop_once();
      end
      chk("fullpp_last", tx_pop_data, 32'h77);
      tx_pop_once();
      chk("fullpp_empty", 32'(tx_empty), 32'd1);
      chk("fullpp_unf",   32'(tx_unf),   32'd0);

      // Push+pop together while empty
      tx_push = 1'b1; tx_pop = 1'b1; tx_data = 32'h12;
      tick();
      tx_push = 1'b0; tx_pop = 1'b0;
      chk("emptypp_count", 32'(tx_count), 32'd1);
      chk("emptypp_head",  tx_pop_data,   32'h12);
      chk("emptypp_unf",   32'(tx_unf),   32'd1);
      tick();

      // Reach count=5 with both flags set, then clear alongside a push
      for (int i = 0; i < 15; i++) tx_push_byte(8'(8'h40 + i));
      tx_push_byte(8'hEE);
      chk("pre_clr_ovf", 32'(tx_ovf), 32'd1);
      for (int i = 0; i < 11; i++) tx_pop_once();
      chk("pre_clr_count", 32'(tx_count), 32'd5);
      chk("pre_clr_unf",   32'(tx_unf),   32'd1);
      clear = 1'b1; tx_push = 1'b1; tx_data = 32'h99;
      tick();
      clear = 1'b0; tx_push = 1'b0;
      chk("clr_count", 32'(tx_count), 32'd0);
      chk("clr_ovf",   32'(tx_ovf),   32'd0);
      chk("clr_unf",   32'(tx_unf),   32'd0);
      chk("clr_empty", 32'(tx_empty), 32'd1);
      chk("clr_data",  tx_pop_data,   32'h0);

      // RX: edge push held for 500 cycles stores one byte
      rx_push = 1'b1; rx_data = 32'hDEADBEEF;
      repeat (500) tick();
      rx_push = 1'b0;
      tick();
      chk("rx_hold_count", 32'(rx_count), 32'd1);
      chk("rx_hold_data",  rx_pop_data,   32'h000000EF);
      // RX: level pop consumes one entry per cycle
      rx_push_once(32'h1A2);
      rx_push_once(32'h3A3);
      chk("rx_count3", 32'(rx_count), 32'd3);
      rx_pop = 1'b1;
      tick(); tick();
      rx_pop = 1'b0;
      chk("rx_lvlpop_count", 32'(rx_count), 32'd1);
      chk("rx_lvlpop_data",  rx_pop_data,   32'hA3);

      // Asynchronous reset in the middle of a level-push burst
      tx_push = 1'b1; tx_data = 32'h5A;
      tick(); tick();
      chk("burst_count", 32'(tx_count), 32'd2);
      #2 axi_resetn = 1'b0;
      #1;
      chk("arst_count", 32'(tx_count), 32'd0);
      chk("arst_empty", 32'(tx_empty), 32'd1);
      chk("arst_data",  tx_pop_data,   32'h0);
      chk("arst_rx_count", 32'(rx_count), 32'd0);
      tx_push = 1'b0;
      tick();
      axi_resetn = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
